char_anim_fsm: RTL and testbench

CHAR_ANIM_FSM -- requirements
Module: char_anim_fsm

---
 rtl/char_anim_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_char_anim_fsm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_anim_fsm.sv
// Sprite animation controller: stand/move/attack/hurt/defend sequencing on frame ticks.
// Optional attack cooldown enabled by defining CHAR_ANIM_COOLDOWN_EN.
module char_anim_fsm #(
    parameter int unsigned FRAME_W         = 8,
    parameter int unsigned DELAY_W         = 8,
    parameter int unsigned STAND_FRAMES    = 8,
    parameter int unsigned STAND_DELAY     = 10,
    parameter int unsigned MOVE_FRAMES     = 4,
    parameter int unsigned MOVE_DELAY      = 10,
    parameter int unsigned ATTACK_FRAMES   = 9,
    parameter int unsigned ATTACK_DELAY    = 3,
    parameter int unsigned HURT_FRAMES     = 4,
    parameter int unsigned HURT_DELAY      = 10,
    parameter int unsigned DEFEND_DELAY    = 3,
    parameter int unsigned ATTACK_COOLDOWN = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               attack,
    input  logic               move_r,
    input  logic               move_l,
    input  logic               hurt,
    input  logic               defend,
    output logic [7:0]         state_out,
    output logic [FRAME_W-1:0] frame_num,
    output logic               move_r1,
    output logic               move_l1,
    output logic               stand1,
    output logic               facing_left,
    output logic               anim_done,
    output logic               hit_blocked,
    output logic               attack_ready
);

    localparam int unsigned FRAME_LIM = 1 << FRAME_W;
    localparam int unsigned DELAY_LIM = 1 << DELAY_W;

    if (FRAME_W > 30 || DELAY_W > 30 ||
        STAND_FRAMES == 0 || STAND_FRAMES > FRAME_LIM ||
        MOVE_FRAMES == 0 || MOVE_FRAMES > FRAME_LIM ||
        ATTACK_FRAMES == 0 || ATTACK_FRAMES > FRAME_LIM ||
        HURT_FRAMES == 0 || HURT_FRAMES > FRAME_LIM ||
        STAND_DELAY >= DELAY_LIM || MOVE_DELAY >= DELAY_LIM ||
        ATTACK_DELAY >= DELAY_LIM || HURT_DELAY >= DELAY_LIM ||
        DEFEND_DELAY >= DELAY_LIM || ATTACK_COOLDOWN > 32'h7fff_ffff) begin : g_bad_params
        $error("char_anim_fsm: parameter exceeds counter range");
    end

    typedef enum logic [2:0] {
        ST_STAND  = 3'd0,
        ST_ATTACK = 3'd1,
        ST_MOVE_L = 3'd2,
        ST_MOVE_R = 3'd3,
        ST_HURT   = 3'd4,
        ST_DEFEND = 3'd5
    } state_t;

    state_t             state;
    logic               frame_clk_q;
    logic               tick;
    logic [DELAY_W-1:0] delay_cnt;
    logic [DELAY_W-1:0] cur_delay;
    logic [DELAY_W-1:0] delay_nxt;
    logic [FRAME_W-1:0] cur_last;
    logic [FRAME_W-1:0] frame_nxt;
    logic               delay_exp;
    logic               frame_last;

    assign state_out = 8'(state);

    // Tick detection: registered rising edge of the frame strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            tick        <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            tick        <= frame_clk & ~frame_clk_q;
        end
    end

    // Per-state animation timing and the "keep animating" next values.
    always_comb begin
        cur_delay = DELAY_W'(STAND_DELAY);
        cur_last  = FRAME_W'(STAND_FRAMES - 1);
        case (state)
            ST_ATTACK: begin
                cur_delay = DELAY_W'(ATTACK_DELAY);
                cur_last  = FRAME_W'(ATTACK_FRAMES - 1);
            end
            ST_MOVE_L, ST_MOVE_R: begin
                cur_delay = DELAY_W'(MOVE_DELAY);
                cur_last  = FRAME_W'(MOVE_FRAMES - 1);
            end
            ST_HURT: begin
                cur_delay = DELAY_W'(HURT_DELAY);
                cur_last  = FRAME_W'(HURT_FRAMES - 1);
            end
            ST_DEFEND: begin
                cur_delay = DELAY_W'(DEFEND_DELAY);
                cur_last  = '0;
            end
            default: ;
        endcase
        delay_exp  = (delay_cnt >= cur_delay);
        frame_last = (frame_num == cur_last);
        delay_nxt  = delay_exp ? '0 : delay_cnt + DELAY_W'(1);
        frame_nxt  = !delay_exp ? frame_num : (frame_last ? '0 : frame_num + FRAME_W'(1));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_STAND;
            delay_cnt   <= '0;
            frame_num   <= '0;
            facing_left <= 1'b0;
            move_r1     <= 1'b0;
            move_l1     <= 1'b0;
            stand1      <= 1'b0;
            anim_done   <= 1'b0;
            hit_blocked <= 1'b0;
        end else begin
            move_r1     <= 1'b0;
            move_l1     <= 1'b0;
            stand1      <= 1'b0;
            anim_done   <= 1'b0;
            hit_blocked <= 1'b0;
            if (tick) begin
                case (state)
                    ST_STAND: begin
                        if (hurt) begin
                            state <= ST_HURT;   delay_cnt <= '0; frame_num <= '0;
                        end else if (attack && attack_ready) begin
                            state <= ST_ATTACK; delay_cnt <= '0; frame_num <= '0;
                        end else if (defend) begin
                            state <= ST_DEFEND; delay_cnt <= '0; frame_num <= '0;
                        end else if (move_r) begin
                            state <= ST_MOVE_R; delay_cnt <= '0; frame_num <= '0;
                            facing_left <= 1'b0;
                            move_r1     <= 1'b1;
                        end else if (move_l) begin
                            state <= ST_MOVE_L; delay_cnt <= '0; frame_num <= '0;
                            facing_left <= 1'b1;
                            move_l1     <= 1'b1;
                        end else begin
                            delay_cnt <= delay_nxt;
                            frame_num <= frame_nxt;
                            stand1    <= 1'b1;
                        end
                    end
                    ST_MOVE_R, ST_MOVE_L: begin
                        if (hurt) begin
                            state <= ST_HURT;   delay_cnt <= '0; frame_num <= '0;
                        end else if ((state == ST_MOVE_R) ? move_r : move_l) begin
                            delay_cnt <= delay_nxt;
                            frame_num <= frame_nxt;
                            move_r1   <= (state == ST_MOVE_R);
                            move_l1   <= (state == ST_MOVE_L);
                        end else if (attack && attack_ready) begin
                            state <= ST_ATTACK; delay_cnt <= '0; frame_num <= '0;
                        end else if (state == ST_MOVE_R && move_l) begin
                            state <= ST_MOVE_L; delay_cnt <= '0; frame_num <= '0;
                            facing_left <= 1'b1;
                            move_l1     <= 1'b1;
                        end else if (state == ST_MOVE_L && move_r) begin
                            state <= ST_MOVE_R; delay_cnt <= '0; frame_num <= '0;
                            facing_left <= 1'b0;
                            move_r1     <= 1'b1;
                        end else begin
                            state <= ST_STAND;  delay_cnt <= '0; frame_num <= '0;
                        end
                    end
                    ST_ATTACK, ST_HURT: begin
                        if (state == ST_ATTACK && hurt) begin
                            state <= ST_HURT;   delay_cnt <= '0; frame_num <= '0;
                        end else if (delay_exp && frame_last) begin
                            state <= ST_STAND;  delay_cnt <= '0; frame_num <= '0;
                            anim_done <= 1'b1;
                        end else begin
                            delay_cnt <= delay_nxt;
                            frame_num <= frame_nxt;
                        end
                    end
                    ST_DEFEND: begin
                        if (hurt) begin
                            hit_blocked <= 1'b1;
                            delay_cnt   <= delay_nxt;
                        end else if (delay_exp && !defend) begin
                            state <= ST_STAND;  delay_cnt <= '0; frame_num <= '0;
                        end else begin
                            delay_cnt <= delay_nxt;
                        end
                    end
                    default: begin
                        state <= ST_STAND;  delay_cnt <= '0; frame_num <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CHAR_ANIM_COOLDOWN_EN
    localparam int unsigned CD_W = (ATTACK_COOLDOWN < 2) ? 1 : $clog2(ATTACK_COOLDOWN + 1);

    logic [CD_W-1:0] cooldown;
    logic [CD_W-1:0] cooldown_nxt;
    logic            cd_load;

    // Cooldown reloads whenever an attack ends, whether completed or preempted by hurt.
    always_comb begin
        cd_load = (state == ST_ATTACK) && (hurt || (delay_exp && frame_last));
        if (cd_load)
            cooldown_nxt = CD_W'(ATTACK_COOLDOWN);
        else if (cooldown != '0)
            cooldown_nxt = cooldown - CD_W'(1);
        else
            cooldown_nxt = cooldown;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cooldown     <= '0;
            attack_ready <= 1'b1;
        end else if (tick) begin
            cooldown     <= cooldown_nxt;
            attack_ready <= (cooldown_nxt == '0);
        end
    end
`else
    assign attack_ready = 1'b1;
`endif

endmodule

// File: tb/tb_char_anim_fsm.sv
// Self-checking bench for char_anim_fsm: per-tick reference model feeding a scoreboard.
`timescale 1ns/1ps
module tb_char_anim_fsm;

    localparam int SF = 8, SD = 10, MF = 4, MD = 10, AF = 9, AD = 3, HF = 4, HD = 10, DD = 3;
    localparam int COOL = 16;
    localparam int S_STAND = 0, S_ATTACK = 1, S_MOVE_L = 2, S_MOVE_R = 3, S_HURT = 4, S_DEFEND = 5;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk, attack, move_r, move_l, hurt, defend;
    logic [7:0] state_out;
    logic [7:0] frame_num;
    logic       move_r1, move_l1, stand1, facing_left, anim_done, hit_blocked, attack_ready;

    char_anim_fsm dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .attack       (attack),
        .move_r       (move_r),
        .move_l       (move_l),
        .hurt         (hurt),
        .defend       (defend),
        .state_out    (state_out),
        .frame_num    (frame_num),
        .move_r1      (move_r1),
        .move_l1      (move_l1),
        .stand1       (stand1),
        .facing_left  (facing_left),
        .anim_done    (anim_done),
        .hit_blocked  (hit_blocked),
        .attack_ready (attack_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int st;
        int fr;
        int s1, ml1, mr1, fl, done, blk, rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: m_t counts ticks since the current animation was entered.
    int m_st, m_t, m_face, m_cd, m_ready;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_STAND; m_t = 0; m_face = 0; m_cd = 0; m_ready = 1;
        sb_q.delete();
    endtask

    task automatic model_enter(input int st);
        m_st = st;
        m_t  = 0;
    endtask

    task automatic model_step(input logic a, r, l, h, d, output exp_t e);
        int load = 0;
        e = '{default: 0};
        case (m_st)
            S_STAND: begin
                if (h) model_enter(S_HURT);
                else if (a && m_ready != 0) model_enter(S_ATTACK);
                else if (d) model_enter(S_DEFEND);
                else if (r) begin model_enter(S_MOVE_R); m_face = 0; e.mr1 = 1; end
                else if (l) begin model_enter(S_MOVE_L); m_face = 1; e.ml1 = 1; end
                else begin m_t = (m_t + 1) % (SF * (SD + 1)); e.s1 = 1; end
            end
            S_MOVE_R, S_MOVE_L: begin
                if (h) model_enter(S_HURT);
                else if ((m_st == S_MOVE_R) ? r : l) begin
                    m_t = (m_t + 1) % (MF * (MD + 1));
                    if (m_st == S_MOVE_R) e.mr1 = 1; else e.ml1 = 1;
                end
                else if (a && m_ready != 0) model_enter(S_ATTACK);
                else if (m_st == S_MOVE_R && l) begin model_enter(S_MOVE_L); m_face = 1; e.ml1 = 1; end
                else if (m_st == S_MOVE_L && r) begin model_enter(S_MOVE_R); m_face = 0; e.mr1 = 1; end
                else model_enter(S_STAND);
            end
            S_ATTACK: begin
                if (h) begin model_enter(S_HURT); load = 1; end
                else if (m_t + 1 == AF * (AD + 1)) begin model_enter(S_STAND); e.done = 1; load = 1; end
                else m_t++;
            end
            S_HURT: begin
                if (m_t + 1 == HF * (HD + 1)) begin model_enter(S_STAND); e.done = 1; end
                else m_t++;
            end
            default: begin
                if (h) e.blk = 1;
                if (((m_t + 1) % (DD + 1)) == 0 && !d && !h) model_enter(S_STAND);
                else m_t = (m_t + 1) % (DD + 1);
            end
        endcase
`ifdef CHAR_ANIM_COOLDOWN_EN
        if (load != 0) m_cd = COOL;
        else if (m_cd > 0) m_cd--;
        m_ready = (m_cd == 0) ? 1 : 0;
`else
        m_ready = (load >= 0) ? 1 : 0;
`endif
        e.st = m_st;
        case (m_st)
            S_STAND:            e.fr = (m_t / (SD + 1)) % SF;
            S_MOVE_R, S_MOVE_L: e.fr = (m_t / (MD + 1)) % MF;
            S_ATTACK:           e.fr = m_t / (AD + 1);
            S_HURT:             e.fr = m_t / (HD + 1);
            default:            e.fr = 0;
        endcase
        e.fl  = m_face;
        e.rdy = m_ready;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check("state",        int'(state_out),    e.st);
        check("frame_num",    int'(frame_num),    e.fr);
        check("stand1",       int'(stand1),       e.s1);
        check("move_l1",      int'(move_l1),      e.ml1);
        check("move_r1",      int'(move_r1),      e.mr1);
        check("facing_left",  int'(facing_left),  e.fl);
        check("anim_done",    int'(anim_done),    e.done);
        check("hit_blocked",  int'(hit_blocked),  e.blk);
        check("attack_ready", int'(attack_ready), e.rdy);
    endtask

    task automatic do_tick(input logic a, r, l, h, d);
        exp_t e;
        @(negedge Clk);
        attack = a; move_r = r; move_l = l; hurt = h; defend = d;
        frame_clk = 1'b1;
        model_step(a, r, l, h, d, e);
        sb_q.push_back(e);
        repeat (2) @(negedge Clk);
        compare_out();
        frame_clk = 1'b0;
        @(negedge Clk);
        check("pulse_width", int'({move_r1, move_l1, stand1, anim_done, hit_blocked}), 0);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b0;
        attack = 0; move_r = 0; move_l = 0; hurt = 0; defend = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        check("rst_state",  int'(state_out),   S_STAND);
        check("rst_frame",  int'(frame_num),   0);
        check("rst_facing", int'(facing_left), 0);
        check("rst_ready",  int'(attack_ready), 1);
        check("rst_pulses", int'({move_r1, move_l1, stand1, anim_done, hit_blocked}), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        attack = 0; move_r = 0; move_l = 0; hurt = 0; defend = 0;
        apply_reset();

        // Idle: stand animation wraps at tick 88.
        repeat (88) do_tick(0, 0, 0, 0, 0);
        check("idle_wrap", int'(frame_num), 0);

        // Single-tick attack, full one-shot and return.
        do_tick(1, 0, 0, 0, 0);
        repeat (40) do_tick(0, 0, 0, 0, 0);

        // Attack held across completion: re-entry timing depends on cooldown.
        repeat (20) do_tick(0, 0, 0, 0, 0);
        repeat (60) do_tick(1, 0, 0, 0, 0);
        repeat (40) do_tick(0, 0, 0, 0, 0);

        // Hurt preempts attack on its 5th tick; hurt inside HURT is ignored.
        repeat (20) do_tick(0, 0, 0, 0, 0);
        do_tick(1, 0, 0, 0, 0);
        repeat (3) do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 1, 0);
        check("hurt_preempt", int'(state_out), S_HURT);
        repeat (3) do_tick(0, 0, 0, 1, 0);
        repeat (45) do_tick(0, 0, 0, 0, 0);

        // Defend with three blocked hits, then release.
        repeat (2) do_tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 0, 0, 1, 1);
            do_tick(0, 0, 0, 0, 1);
        end
        check("defend_hold", int'(state_out), S_DEFEND);
        repeat (6) do_tick(0, 0, 0, 0, 0);

        // Move left 20 ticks, then right; both held selects right.
        repeat (20) do_tick(0, 0, 1, 0, 0);
        check("face_left", int'(facing_left), 1);
        repeat (5) do_tick(0, 1, 0, 0, 0);
        check("face_right", int'(facing_left), 0);
        repeat (3) do_tick(0, 0, 0, 0, 0);
        repeat (3) do_tick(0, 1, 1, 0, 0);
        repeat (3) do_tick(0, 0, 0, 0, 0);

        // Reset mid-MOVE_L.
        repeat (5) do_tick(0, 0, 1, 0, 0);
        apply_reset();
        repeat (3) do_tick(0, 0, 0, 0, 0);

        // Random mix of requests.
        for (int i = 0; i < 400; i++) begin
            do_tick(($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
